turn_scheduler: RTL and testbench
=================================

Name: turn_scheduler

Overview:
- Turn-based sequencer for the two-tank artillery game. Sits between the keyboard keycode bus and the two tank modules.
- Grants keyboard control to exactly one tank at a time, tracks the shell in flight, routes hit pulses and counts lives. Declares game over and the winner.
- All timing is in frames. The block is clocked by frame_clk, like the tank and shell logic.

Parameters:
- TURN_FRAMES, 600, frames a tank may act before its turn is forfeited (10 s at 60 Hz)
- FLIGHT_FRAMES, 300, watchdog on a shell that never reports landing
- SETTLE_FRAMES, 30, pause after landing before the turn passes
- START_HP, 10, lives per tank
- KEY_START, 8'h2C, start/restart key (space)

Ports:
- frame_clk  in  1  frame clock; the only clock
- Reset  in  1  synchronous, active-low reset
- keycode  in  8  raw keyboard keycode
- shootA  in  1  tank A fire pulse
- shootB  in  1  tank B fire pulse
- shell_done  in  1  1-cycle pulse: the active shell has landed or left the screen
- shell_hit  in  1  qualifies shell_done: the shell struck the opponent of shell_owner
- keycodeA  out  8  keycode forwarded to tank A, 0 when A lacks control
- keycodeB  out  8  keycode forwarded to tank B, 0 when B lacks control
- hitA  out  1  1-cycle hit pulse to tank A
- hitB  out  1  1-cycle hit pulse to tank B
- shell_launch  out  1  1-cycle pulse that starts the shell
- shell_owner  out  1  0 = A fired, 1 = B fired; stable for the whole flight
- turn  out  1  0 = A's turn, 1 = B's turn
- turn_left  out  10  frames remaining in the current turn
- livesA  out  4  lives remaining for tank A
- livesB  out  4  lives remaining for tank B
- game_over  out  1  high while in state OVER
- winner  out  1  valid when game_over: 0 = A won, 1 = B won

Behaviour:
- Reset (Reset==0 at a frame_clk edge) values:
  - state = IDLE
  - all pulse outputs 0
  - keycodeA = keycodeB = 0
  - turn = 0, shell_owner = 0, turn_left = 0
  - livesA = livesB = START_HP
  - game_over = 0, winner = 0
- Reset overrides everything, including mid-flight. The shell is abandoned and no hit is issued.
- States: IDLE, TURN, FLIGHT, SETTLE, OVER. The turn register selects the player.
- IDLE:
  - keycodes gated to 0.
  - keycode==KEY_START -> TURN, turn=0, turn_left=TURN_FRAMES-1, lives reloaded to START_HP.
- TURN:
  - Forward keycode combinationally to the active tank; the other tank sees 0.
  - turn_left decrements once per frame.
  - Only the active tank's shoot input is honoured; a shoot pulse from the idle tank is ignored.
  - Active shoot pulse -> FLIGHT. shell_launch=1 for exactly the next cycle; shell_owner=turn; load the flight counter to FLIGHT_FRAMES-1.
  - turn_left==0 with no shoot pulse -> turn forfeited: toggle turn, reload turn_left. No shell, no settle.
  - Shoot pulse in the same cycle as turn_left==0 -> the shot wins, go to FLIGHT.
- FLIGHT:
  - Both keycode outputs are 0, so neither tank moves or aims.
  - On shell_done: if shell_hit, pulse the opponent's hit output for 1 cycle and decrement that tank's lives (saturate at 0). Then go to SETTLE with counter = SETTLE_FRAMES-1.
  - shell_done with shell_hit==0 -> SETTLE, no hit.
  - Flight counter reaching 0 without shell_done -> SETTLE, no hit.
  - shell_done arriving in SETTLE, TURN or IDLE is ignored.
- SETTLE:
  - Keycodes gated.
  - At counter 0: if either life count is 0 -> OVER, winner = the tank with nonzero lives.
  - Otherwise toggle turn, reload turn_left, go to TURN.
- OVER:
  - game_over=1, keycodes gated, lives frozen.
  - keycode==KEY_START -> IDLE for one cycle, then normal start handling applies. Holding the key restarts immediately.
- Width rules:
  - All counters are 10-bit unsigned and must hold FLIGHT_FRAMES-1, TURN_FRAMES-1 and SETTLE_FRAMES-1; elaboration-time check that each parameter is < 1024.
  - Lives are 4-bit; START_HP <= 15.
  - No arithmetic wraps below 0.
- Latency: keycode gating is combinational (0 cycles). All other outputs are registered.

Decomposition:
- Package game_pkg:
  - state enum (IDLE, TURN, FLIGHT, SETTLE, OVER)
  - player constants PLAYER_A=0, PLAYER_B=1
  - keycode constants: KEY_START=8'h2C, KEY_FIRE=8'h28, KEY_RELOAD=8'h13
- Sub-module frame_timer:
  - loadable 10-bit down-counter with load, enable and zero flag.
  - Instantiate twice: one for turn time, one shared by FLIGHT and SETTLE.

Test Plan (TURN_FRAMES=8, FLIGHT_FRAMES=6, SETTLE_FRAMES=2, START_HP=2):
- Release Reset, keycode=8'h2C for 1 frame -> turn=0, turn_left=7. keycode=8'h0D -> keycodeA=8'h0D, keycodeB=0.
- No shot for 8 frames -> turn flips to 1, turn_left=7, shell_launch never asserts, lives stay 2/2.
- shootA pulse in TURN -> shell_launch high exactly 1 cycle next frame, shell_owner=0, keycodeA=keycodeB=0. shootB during that flight -> ignored.
- A fires; shell_done+shell_hit -> hitB single pulse, livesB=1. After 2 settle frames turn=1. Repeat with A's shot in B's turn blocked; B misses (shell_hit=0) -> no hit pulse, turn returns to 0.
- A fires and hits twice -> livesB=0, game_over=1, winner=0 after settle. keycode=8'h2C -> IDLE, then TURN with lives 2/2.
- Edge and reset cases:
  - Reset=0 for 1 cycle mid-FLIGHT -> all outputs at reset values; a following shell_done produces no hitA/hitB.
  - FLIGHT with no shell_done for 6 frames -> watchdog expiry -> SETTLE, no hit.
  - Shoot pulse coincident with turn_left==0 -> FLIGHT, not a forfeit.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the two-tank artillery game.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    FLIGHT,
    SETTLE,
    OVER
  } state_t;

  localparam logic PLAYER_A = 1'b0;
  localparam logic PLAYER_B = 1'b1;

  localparam logic [7:0] KEY_START  = 8'h2C;
  localparam logic [7:0] KEY_FIRE   = 8'h28;
  localparam logic [7:0] KEY_RELOAD = 8'h13;

  function automatic logic [3:0] dec_sat(input logic [3:0] v);
    return (v == '0) ? '0 : v - 4'd1;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter in frames; holds at zero rather than wrapping.
module frame_timer #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             frame_clk,
  input  logic             Reset,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  always_ff @(posedge frame_clk) begin
    if (!Reset)
      count <= '0;
    else if (load)
      count <= load_value;
    else if (en && count != '0)
      count <= count - WIDTH'(1);
  end

  assign zero = (count == '0);

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: grants keyboard control to one tank, tracks the shell, counts lives.
module turn_scheduler #(
  parameter int unsigned TURN_FRAMES   = 600,
  parameter int unsigned FLIGHT_FRAMES = 300,
  parameter int unsigned SETTLE_FRAMES = 30,
  parameter int unsigned START_HP      = 10,
  parameter logic [7:0]  KEY_START     = 8'h2C
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       shootA,
  input  logic       shootB,
  input  logic       shell_done,
  input  logic       shell_hit,
  output logic [7:0] keycodeA,
  output logic [7:0] keycodeB,
  output logic       hitA,
  output logic       hitB,
  output logic       shell_launch,
  output logic       shell_owner,
  output logic       turn,
  output logic [9:0] turn_left,
  output logic [3:0] livesA,
  output logic [3:0] livesB,
  output logic       game_over,
  output logic       winner
);
  import game_pkg::*;

  if (TURN_FRAMES == 0 || TURN_FRAMES >= 1024 ||
      FLIGHT_FRAMES == 0 || FLIGHT_FRAMES >= 1024 ||
      SETTLE_FRAMES == 0 || SETTLE_FRAMES >= 1024) begin : g_bad_frames
    $error("turn_scheduler: frame parameters must be in 1..1023");
  end
  if (START_HP > 15) begin : g_bad_hp
    $error("turn_scheduler: START_HP must fit in 4 bits");
  end

  localparam logic [9:0] TURN_RELOAD   = 10'(TURN_FRAMES - 1);
  localparam logic [9:0] FLIGHT_RELOAD = 10'(FLIGHT_FRAMES - 1);
  localparam logic [9:0] SETTLE_RELOAD = 10'(SETTLE_FRAMES - 1);
  localparam logic [3:0] HP_RELOAD     = 4'(START_HP);

  state_t     state;
  logic       active_shoot;
  logic       turn_load, turn_en, turn_zero;
  logic       phase_load, phase_en, phase_zero;
  logic [9:0] phase_value;
  logic [9:0] phase_left;
  logic       unused_phase_bits;

  assign unused_phase_bits = ^phase_left;

  // Timer controls mirror the state transitions below, so both timers land
  // on their reload values in the same edge that enters the new state.
  always_comb begin
    active_shoot = (turn == PLAYER_B) ? shootB : shootA;
    turn_load    = 1'b0;
    turn_en      = 1'b0;
    phase_load   = 1'b0;
    phase_en     = 1'b0;
    phase_value  = FLIGHT_RELOAD;
    unique case (state)
      IDLE: turn_load = (keycode == KEY_START);
      TURN: begin
        if (active_shoot) begin
          phase_load  = 1'b1;
          phase_value = FLIGHT_RELOAD;
        end else if (turn_zero) begin
          turn_load = 1'b1;
        end else begin
          turn_en = 1'b1;
        end
      end
      FLIGHT: begin
        if (shell_done || phase_zero) begin
          phase_load  = 1'b1;
          phase_value = SETTLE_RELOAD;
        end else begin
          phase_en = 1'b1;
        end
      end
      SETTLE: begin
        if (phase_zero)
          turn_load = (livesA != '0) && (livesB != '0);
        else
          phase_en = 1'b1;
      end
      default: ;
    endcase
  end

  frame_timer #(.WIDTH(10)) u_turn_timer (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .load       (turn_load),
    .en         (turn_en),
    .load_value (TURN_RELOAD),
    .count      (turn_left),
    .zero       (turn_zero)
  );

  frame_timer #(.WIDTH(10)) u_phase_timer (
    .frame_clk  (frame_clk),
    .Reset      (Reset),
    .load       (phase_load),
    .en         (phase_en),
    .load_value (phase_value),
    .count      (phase_left),
    .zero       (phase_zero)
  );

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state        <= IDLE;
      turn         <= PLAYER_A;
      shell_owner  <= PLAYER_A;
      shell_launch <= 1'b0;
      hitA         <= 1'b0;
      hitB         <= 1'b0;
      livesA       <= HP_RELOAD;
      livesB       <= HP_RELOAD;
      game_over    <= 1'b0;
      winner       <= 1'b0;
    end else begin
      shell_launch <= 1'b0;
      hitA         <= 1'b0;
      hitB         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (keycode == KEY_START) begin
            state  <= TURN;
            turn   <= PLAYER_A;
            livesA <= HP_RELOAD;
            livesB <= HP_RELOAD;
          end
        end
        TURN: begin
          if (active_shoot) begin
            state        <= FLIGHT;
            shell_launch <= 1'b1;
            shell_owner  <= turn;
          end else if (turn_zero) begin
            turn <= ~turn;
          end
        end
        FLIGHT: begin
          if (shell_done) begin
            if (shell_hit) begin
              if (shell_owner == PLAYER_A) begin
                hitB   <= 1'b1;
                livesB <= dec_sat(livesB);
              end else begin
                hitA   <= 1'b1;
                livesA <= dec_sat(livesA);
              end
            end
            state <= SETTLE;
          end else if (phase_zero) begin
            state <= SETTLE;
          end
        end
        SETTLE: begin
          if (phase_zero) begin
            if (livesA == '0 || livesB == '0) begin
              state     <= OVER;
              game_over <= 1'b1;
              winner    <= (livesA == '0) ? PLAYER_B : PLAYER_A;
            end else begin
              state <= TURN;
              turn  <= ~turn;
            end
          end
        end
        OVER: begin
          if (keycode == KEY_START) begin
            state     <= IDLE;
            game_over <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign keycodeA = (state == TURN && turn == PLAYER_A) ? keycode : '0;
  assign keycodeB = (state == TURN && turn == PLAYER_B) ? keycode : '0;

endmodule

// File: tb/tb_turn_scheduler.sv
// Bench for turn_scheduler: scripted vector table, multi-cycle corner sequences, random vs. model.
module tb_turn_scheduler;

  localparam int TF = 8, FF = 6, SF = 2, HP = 2;
  localparam logic [9:0] DC = 10'h3FF;

  logic       frame_clk, Reset;
  logic [7:0] keycode;
  logic       shootA, shootB, shell_done, shell_hit;
  logic [7:0] keycodeA, keycodeB;
  logic       hitA, hitB, shell_launch, shell_owner, turn;
  logic [9:0] turn_left;
  logic [3:0] livesA, livesB;
  logic       game_over, winner;

  turn_scheduler #(
    .TURN_FRAMES(TF), .FLIGHT_FRAMES(FF), .SETTLE_FRAMES(SF),
    .START_HP(HP), .KEY_START(8'h2C)
  ) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
    .shootA(shootA), .shootB(shootB), .shell_done(shell_done), .shell_hit(shell_hit),
    .keycodeA(keycodeA), .keycodeB(keycodeB), .hitA(hitA), .hitB(hitB),
    .shell_launch(shell_launch), .shell_owner(shell_owner), .turn(turn),
    .turn_left(turn_left), .livesA(livesA), .livesB(livesB),
    .game_over(game_over), .winner(winner)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] pre_kA, pre_kB;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // {turn, shell_launch, shell_owner, hitA, hitB, livesA, livesB, game_over, winner}
  function automatic logic [14:0] regs_now();
    return {turn, shell_launch, shell_owner, hitA, hitB, livesA, livesB, game_over, winner};
  endfunction

  task automatic step(input logic r, input logic [7:0] k, input logic a, input logic b,
                      input logic d, input logic h);
    Reset = r; keycode = k; shootA = a; shootB = b; shell_done = d; shell_hit = h;
    #1;
    pre_kA = keycodeA;
    pre_kB = keycodeB;
    @(posedge frame_clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] kc;
    logic       sa, sb, dn, ht;
    logic [7:0] ekA, ekB;
    logic       eturn;
    logic [9:0] etl;
    logic       elaunch, eowner, ehA, ehB;
    logic [3:0] eLA, eLB;
    logic       ego, ewin;
  } vec_t;

  function automatic vec_t mk(logic [7:0] kc, logic sa, logic sb, logic dn, logic ht,
                              logic [7:0] ekA, logic [7:0] ekB, logic eturn, logic [9:0] etl,
                              logic el, logic eo, logic eha, logic ehb,
                              logic [3:0] la, logic [3:0] lb, logic go, logic w);
    vec_t v;
    v.kc = kc; v.sa = sa; v.sb = sb; v.dn = dn; v.ht = ht;
    v.ekA = ekA; v.ekB = ekB; v.eturn = eturn; v.etl = etl;
    v.elaunch = el; v.eowner = eo; v.ehA = eha; v.ehB = ehb;
    v.eLA = la; v.eLB = lb; v.ego = go; v.ewin = w;
    return v;
  endfunction

  // Behavioural model: game phase plus per-phase frame budgets.
  localparam int P_IDLE = 0, P_TURN = 1, P_FLIGHT = 2, P_SETTLE = 3, P_OVER = 4;
  int m_ph, m_turn, m_tl, m_fl, m_sl, m_owner, m_la, m_lb, m_over, m_win;
  int m_launch, m_hA, m_hB;

  function automatic void model_reset();
    m_ph = P_IDLE; m_turn = 0; m_tl = 0; m_fl = 0; m_sl = 0; m_owner = 0;
    m_la = HP; m_lb = HP; m_over = 0; m_win = 0; m_launch = 0; m_hA = 0; m_hB = 0;
  endfunction

  function automatic void model_step(logic r, logic [7:0] k, logic a, logic b, logic d, logic h);
    int shot;
    if (!r) begin model_reset(); return; end
    m_launch = 0; m_hA = 0; m_hB = 0;
    case (m_ph)
      P_IDLE: if (k == 8'h2C) begin m_ph = P_TURN; m_turn = 0; m_tl = TF - 1; m_la = HP; m_lb = HP; end
      P_TURN: begin
        shot = (m_turn == 1) ? b : a;
        if (shot != 0) begin m_ph = P_FLIGHT; m_launch = 1; m_owner = m_turn; m_fl = FF - 1; end
        else if (m_tl == 0) begin m_turn = 1 - m_turn; m_tl = TF - 1; end
        else m_tl = m_tl - 1;
      end
      P_FLIGHT: begin
        if (d) begin
          if (h) begin
            if (m_owner == 0) begin m_hB = 1; if (m_lb > 0) m_lb = m_lb - 1; end
            else begin m_hA = 1; if (m_la > 0) m_la = m_la - 1; end
          end
          m_ph = P_SETTLE; m_sl = SF - 1;
        end else if (m_fl == 0) begin m_ph = P_SETTLE; m_sl = SF - 1; end
        else m_fl = m_fl - 1;
      end
      P_SETTLE: begin
        if (m_sl == 0) begin
          if (m_la == 0 || m_lb == 0) begin m_ph = P_OVER; m_over = 1; m_win = (m_la == 0) ? 1 : 0; end
          else begin m_turn = 1 - m_turn; m_tl = TF - 1; m_ph = P_TURN; end
        end else m_sl = m_sl - 1;
      end
      default: if (k == 8'h2C) begin m_ph = P_IDLE; m_over = 0; end
    endcase
  endfunction

  vec_t tbl[$];

  initial begin
    Reset = 1'b0; keycode = '0; shootA = 0; shootB = 0; shell_done = 0; shell_hit = 0;

    // Reset values
    step(0, 8'h2C, 0, 0, 0, 0);
    step(0, 8'h0D, 1, 1, 1, 1);
    chk("reset_regs", 32'(regs_now()), 32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 1'b0, 1'b0}));
    chk("reset_turn_left", 32'(turn_left), 32'd0);
    chk("reset_keycodes", {keycodeA, keycodeB}, 32'd0);

    // Scripted game: forfeit, B miss, A hit, blocked shots, A wins, restart
    tbl.push_back(mk(8'h2C,0,0,0,0, 8'h00,8'h00, 0,10'd7, 0,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h0D,0,0,0,0, 8'h0D,8'h00, 0,10'd6, 0,0,0,0, 2,2,0,0));
    for (int i = 5; i >= 0; i--)
      tbl.push_back(mk(8'h0D,0,0,0,0, 8'h0D,8'h00, 0,10'(i), 0,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h0D,0,0,0,0, 8'h0D,8'h00, 1,10'd7, 0,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h1D,1,0,0,0, 8'h00,8'h1D, 1,10'd6, 0,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h00,0,1,0,0, 8'h00,8'h00, 1,DC,    1,1,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h0D,1,0,0,0, 8'h00,8'h00, 1,DC,    0,1,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h00,0,0,1,0, 8'h00,8'h00, 1,DC,    0,1,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 1,DC,    0,1,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 0,10'd7, 0,1,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h0D,1,0,0,0, 8'h0D,8'h00, 0,DC,    1,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h0D,0,1,0,0, 8'h00,8'h00, 0,DC,    0,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h00,0,0,1,1, 8'h00,8'h00, 0,DC,    0,0,0,1, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 0,DC,    0,0,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 1,10'd7, 0,0,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h0D,1,0,0,0, 8'h00,8'h0D, 1,10'd6, 0,0,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,1,0,0, 8'h00,8'h00, 1,DC,    1,1,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,0,1,0, 8'h00,8'h00, 1,DC,    0,1,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 1,DC,    0,1,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 0,10'd7, 0,1,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,1,0,0,0, 8'h00,8'h00, 0,DC,    1,0,0,0, 2,1,0,0));
    tbl.push_back(mk(8'h00,0,0,1,1, 8'h00,8'h00, 0,DC,    0,0,0,1, 2,0,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 0,DC,    0,0,0,0, 2,0,0,0));
    tbl.push_back(mk(8'h00,0,0,0,0, 8'h00,8'h00, 0,DC,    0,0,0,0, 2,0,1,0));
    tbl.push_back(mk(8'h0D,0,0,0,0, 8'h00,8'h00, 0,DC,    0,0,0,0, 2,0,1,0));
    tbl.push_back(mk(8'h2C,0,0,1,1, 8'h00,8'h00, 0,DC,    0,0,0,0, 2,0,0,0));
    tbl.push_back(mk(8'h2C,0,0,0,0, 8'h00,8'h00, 0,10'd7, 0,0,0,0, 2,2,0,0));
    tbl.push_back(mk(8'h0D,0,0,0,0, 8'h0D,8'h00, 0,10'd6, 0,0,0,0, 2,2,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(1, tbl[i].kc, tbl[i].sa, tbl[i].sb, tbl[i].dn, tbl[i].ht);
      chk($sformatf("vec%0d_keys", i), {16'd0, pre_kA, pre_kB}, {16'd0, tbl[i].ekA, tbl[i].ekB});
      chk($sformatf("vec%0d_regs", i), 32'(regs_now()),
          32'({tbl[i].eturn, tbl[i].elaunch, tbl[i].eowner, tbl[i].ehA, tbl[i].ehB,
               tbl[i].eLA, tbl[i].eLB, tbl[i].ego, tbl[i].ewin}));
      if (tbl[i].etl != DC)
        chk($sformatf("vec%0d_turn_left", i), 32'(turn_left), 32'(tbl[i].etl));
    end

    // Reset mid-flight abandons the shell; a late shell_done is ignored
    step(1, 8'h00, 1, 0, 0, 0);
    chk("midflight_launch", {shell_launch, shell_owner}, 32'b10);
    step(0, 8'h0D, 0, 0, 0, 0);
    chk("midflight_reset_regs", 32'(regs_now()), 32'({7'b0, 4'd2, 4'd2, 2'b0}));
    chk("midflight_reset_tl", 32'(turn_left), 32'd0);
    chk("midflight_reset_keys", {keycodeA, keycodeB}, 32'd0);
    step(1, 8'h00, 0, 0, 1, 1);
    chk("midflight_late_done", {hitA, hitB, livesA, livesB}, {2'b00, 4'd2, 4'd2});

    // Watchdog: six silent flight frames, then settle ignores shell_done
    step(1, 8'h2C, 0, 0, 0, 0);
    step(1, 8'h00, 1, 0, 0, 0);
    for (int i = 0; i < FF; i++) step(1, 8'h00, 0, 0, 0, 0);
    step(1, 8'h00, 0, 0, 1, 1);
    chk("watchdog_no_hit", {hitA, hitB, livesA, livesB}, {2'b00, 4'd2, 4'd2});
    step(1, 8'h00, 0, 0, 0, 0);
    chk("watchdog_turn_passes", {turn, turn_left}, {1'b1, 10'd7});

    // Shot in the last turn frame beats the forfeit
    for (int i = 0; i < TF - 1; i++) step(1, 8'h00, 0, 0, 0, 0);
    chk("last_frame_tl", 32'(turn_left), 32'd0);
    step(1, 8'h00, 0, 1, 0, 0);
    chk("last_frame_shot", {turn, shell_launch, shell_owner}, 32'b111);

    // Random stimulus against the model
    step(0, 8'h00, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic r, a, b, d, h;
      logic [7:0] k;
      logic [7:0] ekA, ekB;
      r = ($urandom_range(0, 99) != 0);
      k = ($urandom_range(0, 3) == 0) ? 8'h2C : 8'($urandom);
      a = ($urandom_range(0, 4) == 0);
      b = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 3) == 0);
      h = ($urandom_range(0, 1) == 0);
      ekA = (m_ph == P_TURN && m_turn == 0) ? k : 8'h00;
      ekB = (m_ph == P_TURN && m_turn == 1) ? k : 8'h00;
      step(r, k, a, b, d, h);
      chk($sformatf("rand%0d_keys", i), {16'd0, pre_kA, pre_kB}, {16'd0, ekA, ekB});
      model_step(r, k, a, b, d, h);
      chk($sformatf("rand%0d_regs", i), 32'(regs_now()),
          32'({1'(m_turn), 1'(m_launch), 1'(m_owner), 1'(m_hA), 1'(m_hB),
               4'(m_la), 4'(m_lb), 1'(m_over), 1'(m_win)}));
      if (m_ph == P_TURN || !r)
        chk($sformatf("rand%0d_turn_left", i), 32'(turn_left), 32'(m_tl));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
